uart_full_duplex: RTL and testbench
===================================

// Module: uart_full_duplex
// PURPOSE
//  Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock/reset.
//  Serialises a parallel byte onto tx_serial; deserialises rx_serial into a byte.
//  Sits between a host-side byte interface and the chip's serial pins.
//  Hierarchy: instance my_uart_tx (transmitter, contains baud_tick) plus a receiver instance.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD_RATE  115200      serial bit rate, bits/s
//  DIVISOR (localparam) = CLK_FREQ/BAUD_RATE, integer division (434 at defaults) = clocks per bit
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_       in   1  asynchronous, active-low reset
//  tx_start   in   1  request to send tx_data (level, sampled only when TX idle)
//  tx_data    in   8  byte to transmit, latched when the request is accepted
//  rx_serial  in   1  serial input line, idle high, asynchronous to clk
//  tx_serial  out  1  serial output line, idle high
//  rx_data    out  8  last received byte
//  rx_valid   out  1  1-cycle pulse: byte received with good stop bit
//  rx_error   out  1  1-cycle pulse: byte received with stop bit = 0 (framing error)
//  tx_busy    out  1  high while a TX frame is in progress
// BEHAVIOUR
//  Reset (async, rst_=0): tx_serial=1, tx_busy=0, rx_data=0, rx_valid=0, rx_error=0; both FSMs IDLE; counters 0.
//  Frame: start bit 0, data bits 0..7 (LSB first), stop bit 1; each bit lasts exactly DIVISOR clocks.
//  TX FSM: IDLE -> START -> DATA(x8) -> STOP -> IDLE.
//   - IDLE, tx_start=1 at posedge: latch tx_data, tx_serial<=0, tx_busy<=1, clear baud counter.
//   - Baud counter counts 0..DIVISOR-1; baud_tick = (count==DIVISOR-1), marks the END of a bit period.
//   - On the clock edge where baud_tick=1, advance to the next bit; tx_serial is stable while tick is high.
//   - 10th tick (end of stop bit): return to IDLE, tx_busy<=0, tx_serial stays 1.
//   - tx_start while busy is ignored; in-flight frame and latched byte are unaffected.
//   - tx_start still high on the first IDLE cycle after a frame starts a new frame (level-sensitive).
//  RX path: rx_serial passes through a 2-flop synchronizer before any use.
//  RX FSM: IDLE -> START -> DATA(x8) -> STOP -> IDLE (or WAIT_HIGH).
//   - IDLE: synchronized line 0 -> START, counter cleared.
//   - START: after DIVISOR/2 clocks (mid-bit) re-sample; 1 = false start -> IDLE, no outputs; 0 -> DATA.
//   - DATA: sample every DIVISOR clocks at mid-bit, shift in LSB first, 8 samples.
//   - STOP: sample at mid-bit; rx_data<=shifted byte in both outcomes.
//     1: rx_valid pulses 1 cycle -> IDLE.  0: rx_error pulses 1 cycle -> WAIT_HIGH.
//   - WAIT_HIGH: stay until synchronized line = 1, then IDLE (no spurious start from a held-low line).
//   - rx_valid and rx_error never high together; both 0 except the single pulse cycle.
//   - rx_data holds its value until the next completed frame.
//  TX and RX fully independent: simultaneous operation is required, no shared state.
//  Reset mid-frame: both FSMs abort immediately to IDLE with reset values; no partial pulse.
// TESTING (clk period 10, defaults, DIVISOR=434)
//  1 Reset: rst_ low 2 cycles -> tx_serial=1, tx_busy=0, rx_valid=rx_error=0, rx_data=0.
//  2 TX 8'hFF: tx_start high 2 cycles -> at 10 successive baud_ticks tx_serial = 0,1,1,1,1,1,1,1,1,1;
//    tx_busy high across frame, low after.
//  3 RX 8'hFF: drive 0,1x8,1 at 434-clk bits -> one rx_valid pulse, rx_data=8'hFF, rx_error=0.
//  4 Simultaneous TX 8'hFF and RX 8'hFF -> both frames correct as in 2 and 3.
//  5 False start: rx_serial low 10 clks then high -> no rx_valid/rx_error, RX returns IDLE.
//    Concurrent TX: tx_start re-pulsed mid-frame after 6th tick -> frame unchanged, no restart.
//  6 Framing error: drive 0,1x8,0 then line high -> one rx_error pulse, rx_valid=0,
//    rx_data=8'hFF; next good frame is received normally.

Source files
------------

// File: rtl/uart_full_duplex.sv
// rtl/uart_full_duplex.sv - full-duplex 8N1 UART: independent transmitter and receiver on one clock
module uart_tx #(
    parameter int DIVISOR = 434
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_busy
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t      state, next_state;
    logic [CW-1:0]  count;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           baud_tick;

    // Tick marks the last clock of the current bit period.
    assign baud_tick = (state != TX_IDLE) && (count == CW'(DIVISOR - 1));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= TX_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TX_IDLE:  if (tx_start) next_state = TX_START;
            TX_START: if (baud_tick) next_state = TX_DATA;
            TX_DATA:  if (baud_tick && bit_idx == 3'd7) next_state = TX_STOP;
            TX_STOP:  if (baud_tick) next_state = TX_IDLE;
            default:  next_state = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_serial = 1'b1;
        tx_busy   = (state != TX_IDLE);
        case (state)
            TX_START: tx_serial = 1'b0;
            TX_DATA:  tx_serial = shift[bit_idx];
            default:  tx_serial = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (state == TX_IDLE) begin
            count   <= '0;
            bit_idx <= '0;
            if (tx_start) shift <= tx_data;
        end else if (baud_tick) begin
            count <= '0;
            if (state == TX_DATA) bit_idx <= bit_idx + 3'd1;
        end else begin
            count <= count + CW'(1);
        end
    end
endmodule

module uart_rx #(
    parameter int DIVISOR = 434
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    rx_state_t      state, next_state;
    logic [1:0]     sync;
    logic           line;
    logic [CW-1:0]  count;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           sample;
    logic           frame_good;
    logic           frame_bad;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) sync <= 2'b11;
        else       sync <= {sync[0], rx_serial};
    end
    assign line = sync[1];

    // Start bit is checked half a bit in; every later sample is a full bit apart, i.e. mid-bit.
    assign sample = ((state == RX_START) && (count == CW'(DIVISOR / 2 - 1))) ||
                    (((state == RX_DATA) || (state == RX_STOP)) && (count == CW'(DIVISOR - 1)));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= RX_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RX_IDLE:      if (!line) next_state = RX_START;
            RX_START:     if (sample) next_state = line ? RX_IDLE : RX_DATA;
            RX_DATA:      if (sample && bit_idx == 3'd7) next_state = RX_STOP;
            RX_STOP:      if (sample) next_state = line ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (line) next_state = RX_IDLE;
            default:      next_state = RX_IDLE;
        endcase
    end

    always_comb begin
        frame_good = (state == RX_STOP) && sample && line;
        frame_bad  = (state == RX_STOP) && sample && !line;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_valid <= frame_good;
            rx_error <= frame_bad;
            if (frame_good || frame_bad) rx_data <= shift;
            if ((state == RX_START || state == RX_DATA || state == RX_STOP) && !sample)
                count <= count + CW'(1);
            else
                count <= '0;
            if (state == RX_START) bit_idx <= '0;
            if (state == RX_DATA && sample) begin
                bit_idx <= bit_idx + 3'd1;
                shift   <= {line, shift[7:1]};
            end
        end
    end
endmodule

module uart_full_duplex #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       rx_serial,
    output logic       tx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       tx_busy
);
    localparam int DIVISOR = CLK_FREQ / BAUD_RATE;

    uart_tx #(.DIVISOR(DIVISOR)) my_uart_tx (
        .clk       (clk),
        .rst_      (rst_),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy)
    );

    uart_rx #(.DIVISOR(DIVISOR)) my_uart_rx (
        .clk       (clk),
        .rst_      (rst_),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error)
    );
endmodule

// File: tb/tb_uart_full_duplex.sv
// tb/tb_uart_full_duplex.sv - randomized self-checking bench for uart_full_duplex
module tb_uart_full_duplex;
    localparam int DIV = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_serial = 1'b1;
    logic       tx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       tx_busy;

    int n_cmp = 0, n_bad = 0;
    int valid_cnt = 0, error_cnt = 0, both_cnt = 0;
    int exp_valid = 0, exp_error = 0;
    logic [7:0] exp_rx_data = 8'h00;

    uart_full_duplex dut (
        .clk       (clk),
        .rst_      (rst_),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .rx_serial (rx_serial),
        .tx_serial (tx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) valid_cnt <= valid_cnt + 1;
        if (rx_error) error_cnt <= error_cnt + 1;
        if (rx_valid && rx_error) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rx_model();
        check("rx_valid_count", valid_cnt, exp_valid);
        check("rx_error_count", error_cnt, exp_error);
        check("rx_both_high", both_cnt, 0);
        check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx_data});
    endtask

    // Expected line: 10 bits of DIV clocks each (start, data LSB first, stop), then idle.
    // hold = cycles tx_start stays high (0 = leave it high for a chained frame).
    task automatic tx_frame(input logic [7:0] d, input int hold, input bit repulse);
        logic [9:0] fr;
        int ph;
        fr = {1'b1, d, 1'b0};
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc <= 10 * DIV; cyc++) begin
            ph = cyc % DIV;
            if (cyc == 10 * DIV) begin
                check("tx_serial_idle", {31'h0, tx_serial}, 32'd1);
                check("tx_busy_end", {31'h0, tx_busy}, 32'd0);
            end else if (ph == 0 || ph == DIV / 2 || ph == DIV - 1) begin
                check("tx_serial_bit", {31'h0, tx_serial}, {31'h0, fr[cyc / DIV]});
                check("tx_busy_frame", {31'h0, tx_busy}, 32'd1);
            end
            if (cyc == 0 && hold != 0) tx_data = 8'($urandom);
            if (hold != 0 && cyc == hold - 1) tx_start = 1'b0;
            if (repulse && cyc == 6 * DIV + 5) begin
                tx_start = 1'b1;
                tx_data  = 8'($urandom);
            end
            if (repulse && cyc == 6 * DIV + 8) tx_start = 1'b0;
            if (cyc < 10 * DIV) @(negedge clk);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx_serial = fr[b];
            repeat (DIV) @(negedge clk);
        end
        rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        if (stop) exp_valid++;
        else      exp_error++;
        exp_rx_data = d;
        check_rx_model();
    endtask

    initial begin
        logic [7:0] r1, r2;
        repeat (2) @(negedge clk);
        check("reset_tx_serial", {31'h0, tx_serial}, 32'd1);
        check("reset_tx_busy", {31'h0, tx_busy}, 32'd0);
        check("reset_rx_valid", {31'h0, rx_valid}, 32'd0);
        check("reset_rx_error", {31'h0, rx_error}, 32'd0);
        check("reset_rx_data", {24'h0, rx_data}, 32'd0);
        rst_ = 1'b1;
        @(negedge clk);
        check("post_reset_tx_serial", {31'h0, tx_serial}, 32'd1);

        tx_frame(8'hFF, 2, 1'b0);
        rx_frame(8'hFF, 1'b1);

        fork
            tx_frame(8'hFF, 2, 1'b0);
            rx_frame(8'hFF, 1'b1);
        join

        // False start on RX while TX sees a mid-frame re-request.
        fork
            tx_frame(8'($urandom), 1, 1'b1);
            begin
                rx_serial = 1'b0;
                repeat (10) @(negedge clk);
                rx_serial = 1'b1;
                repeat (600) @(negedge clk);
                check_rx_model();
            end
        join

        fork
            tx_frame(8'($urandom), 3, 1'b0);
            rx_frame(8'hFF, 1'b0);
        join
        rx_frame(8'($urandom), 1'b1);

        // Level-sensitive request: second frame starts on the first idle cycle.
        tx_frame(8'($urandom), 0, 1'b0);
        tx_frame(8'($urandom), 1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            fork
                tx_frame(r1, int'($urandom_range(1, 3)), 1'b0);
                rx_frame(r2, 1'b1);
            join
        end
        rx_frame(8'h5A, 1'b1);

        tx_data  = 8'($urandom);
        tx_start = 1'b1;
        rx_serial = 1'b0;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (1500) @(negedge clk);
        check("pre_reset_tx_busy", {31'h0, tx_busy}, 32'd1);
        rst_ = 1'b0;
        #1;
        check("midreset_tx_serial", {31'h0, tx_serial}, 32'd1);
        check("midreset_tx_busy", {31'h0, tx_busy}, 32'd0);
        check("midreset_rx_data", {24'h0, rx_data}, 32'd0);
        check("midreset_rx_valid", {31'h0, rx_valid}, 32'd0);
        check("midreset_rx_error", {31'h0, rx_error}, 32'd0);
        rx_serial = 1'b1;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        exp_rx_data = 8'h00;
        repeat (3000) @(negedge clk);
        check_rx_model();
        check("after_reset_tx_busy", {31'h0, tx_busy}, 32'd0);
        check("after_reset_tx_serial", {31'h0, tx_serial}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
